sar_sample_averager: RTL

SAR_SAMPLE_AVERAGER -- requirements
Module: sar_sample_averager

---
 rtl/sar_sample_averager.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sar_sample_averager.sv
`default_nettype none
// ============================================================================
//  Module   : sar_sample_averager
//  Purpose  : Captures SAR conversion results on the rising edge of sar_done,
//             re-arms the SAR with a fixed-width restart pulse, and averages
//             1/2/4/8 samples into a handshaked output register.
//  Revision : 1.0  initial release
// ============================================================================
module sar_sample_averager #(
   parameter int RESTART_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sar_data,
   input  logic       sar_done,
   input  logic [1:0] avg_sel,
   input  logic       out_ready,
   input  logic       clr_overrun,
   output logic       sar_restart,
   output logic [7:0] avg_out,
   output logic       avg_valid,
   output logic       overrun,
   output logic [2:0] sample_cnt
);

   // Restart counter loads with the number of remaining high cycles minus one.
   localparam logic [3:0] RESTART_LAST = 4'(RESTART_CYCLES - 1);

   typedef enum logic [0:0] {
      WAIT_DONE = 1'b0,
      RESTART   = 1'b1
   } state_t;

   state_t      state;
   logic        done_q;
   logic [3:0]  restart_cnt;
   logic [10:0] acc;
   logic [1:0]  sel_q;

   logic        capture;
   logic [1:0]  eff_sel;
   logic [2:0]  last_cnt;
   logic        last_sample;
   logic [10:0] sum;
   logic [7:0]  avg_new;
   logic        complete;
   logic        out_free;

   // Capture decode, effective block size and completed-average arithmetic.
   always_comb begin
      capture  = (state == WAIT_DONE) && sar_done && !done_q;
      // The first capture of a block uses the live select; later ones the latched copy.
      eff_sel  = (sample_cnt == 3'd0) ? avg_sel : sel_q;
      last_cnt = 3'd0;
      case (eff_sel)
         2'd0:    last_cnt = 3'd0;
         2'd1:    last_cnt = 3'd1;
         2'd2:    last_cnt = 3'd3;
         default: last_cnt = 3'd7;
      endcase
      last_sample = (sample_cnt == last_cnt);
      sum         = acc + {3'd0, sar_data};
      avg_new     = 8'(sum >> eff_sel);
      complete    = capture && last_sample;
      out_free    = !avg_valid || out_ready;
   end

   // Edge-detect history for sar_done; tracks the level in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= sar_done;
      end
   end

   // Capture/restart FSM with a registered restart pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT_DONE;
         sar_restart <= 1'b0;
         restart_cnt <= 4'd0;
      end else begin
         case (state)
            WAIT_DONE: begin
               if (capture) begin
                  state       <= RESTART;
                  sar_restart <= 1'b1;
                  restart_cnt <= RESTART_LAST;
               end
            end
            RESTART: begin
               if (restart_cnt == 4'd0) begin
                  state       <= WAIT_DONE;
                  sar_restart <= 1'b0;
               end else begin
                  restart_cnt <= restart_cnt - 4'd1;
               end
            end
            default: begin
               state       <= WAIT_DONE;
               sar_restart <= 1'b0;
               restart_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Accumulator, sample counter and per-block select latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= 11'd0;
         sample_cnt <= 3'd0;
         sel_q      <= 2'd0;
      end else if (capture) begin
         if (sample_cnt == 3'd0) begin
            sel_q <= avg_sel;
         end
         if (last_sample) begin
            acc        <= 11'd0;
            sample_cnt <= 3'd0;
         end else begin
            acc        <= sum;
            sample_cnt <= sample_cnt + 3'd1;
         end
      end
   end

   // Output register with ready/valid handshake; a result arriving while the
   // register is still occupied is dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avg_out   <= 8'h00;
         avg_valid <= 1'b0;
      end else if (complete && out_free) begin
         avg_out   <= avg_new;
         avg_valid <= 1'b1;
      end else if (avg_valid && out_ready) begin
         avg_valid <= 1'b0;
      end
   end

   // Sticky overrun; a new overrun event has priority over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (complete && !out_free) begin
         overrun <= 1'b1;
      end else if (clr_overrun) begin
         overrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire
